// File: rtl/debug_halt_ctrl.sv
// Debug halt controller: drains the core pipeline, flushes it, parks in HALTED and
// sequences resume / single-step requests from the debug module.
module debug_halt_ctrl #(
   parameter int unsigned DRAIN_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        dm_haltreq_i,
   input  logic        dm_resumereq_i,
   input  logic        dm_step_i,
   input  logic        ht_inst_comp_i,
   input  logic [31:0] ht_pc_i,
   output logic        ht_halt_active_o,
   output logic        ht_reset_stages_o,
   output logic        dm_halted_o,
   output logic        dm_resumeack_o,
   output logic [31:0] dm_dpc_o,
   output logic        dm_drain_err_o
);

   typedef enum logic [2:0] {
      ST_RUN,
      ST_DRAIN,
      ST_FLUSH,
      ST_HALTED,
      ST_RESUME,
      ST_STEP
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(DRAIN_TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] dpc_q, dpc_d;
   logic        err_q, err_d;
   logic        resreq_q, stepreq_q;
   logic        resume_edge, step_edge;

   // A held request level must drop before HALTED accepts it again.
   assign resume_edge = dm_resumereq_i & ~resreq_q;
   assign step_edge   = dm_step_i & ~stepreq_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q     <= '0;
         dpc_q     <= '0;
         err_q     <= 1'b0;
         resreq_q  <= 1'b0;
         stepreq_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         dpc_q     <= dpc_d;
         err_q     <= err_d;
         resreq_q  <= dm_resumereq_i;
         stepreq_q <= dm_step_i;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dpc_d   = dpc_q;
      err_d   = err_q;
      case (state_q)
         ST_RUN: begin
            if (dm_haltreq_i) begin
               state_d = ST_DRAIN;
               cnt_d   = '0;
            end
         end
         ST_DRAIN: begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 8'd1;
            // Completion wins over a coincident timeout.
            if (ht_inst_comp_i) begin
               state_d = ST_FLUSH;
               err_d   = 1'b0;
               dpc_d   = ht_pc_i;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_FLUSH;
               err_d   = 1'b1;
               dpc_d   = ht_pc_i;
            end
         end
         ST_FLUSH:  state_d = ST_HALTED;
         ST_HALTED: begin
            if (resume_edge) begin
               state_d = ST_RESUME;
            end else if (step_edge) begin
               state_d = ST_STEP;
            end
         end
         ST_RESUME: state_d = ST_RUN;
         ST_STEP: begin
            state_d = ST_DRAIN;
            cnt_d   = '0;
         end
         default:   state_d = ST_RUN;
      endcase
   end

   always_comb begin
      ht_halt_active_o  = 1'b0;
      ht_reset_stages_o = 1'b0;
      dm_halted_o       = 1'b0;
      dm_resumeack_o    = 1'b0;
      case (state_q)
         ST_DRAIN:  ht_halt_active_o = 1'b1;
         ST_FLUSH: begin
            ht_halt_active_o  = 1'b1;
            ht_reset_stages_o = 1'b1;
         end
         ST_HALTED: begin
            ht_halt_active_o = 1'b1;
            dm_halted_o      = 1'b1;
         end
         ST_RESUME: dm_resumeack_o = 1'b1;
         default: ;
      endcase
   end

   assign dm_dpc_o       = dpc_q;
   assign dm_drain_err_o = err_q;

endmodule

// File: doc/debug_halt_ctrl.md
DEBUG_HALT_CTRL -- requirements
Module: debug_halt_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_TIMEOUT, default 16: maximum cycles spent in DRAIN waiting for ht_inst_comp_i (legal range 1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port dm_haltreq_i  input  1  debugger halt request, level.
REQ-005 SHALL have port dm_resumereq_i  input  1  debugger resume request, level.
REQ-006 SHALL have port dm_step_i  input  1  debugger single-step request, level.
REQ-007 SHALL have port ht_inst_comp_i  input  1  core reports pipeline drained (stage 2 and stage 3 hold no live work).
REQ-008 SHALL have port ht_pc_i  input  32  core fetch PC.
REQ-009 SHALL have port ht_halt_active_o  output  1  to core: freeze PC and inject NOP into fetch.
REQ-010 SHALL have port ht_reset_stages_o  output  1  to core: clear pipeline stage registers.
REQ-011 SHALL have port dm_halted_o  output  1  core halted and safe.
REQ-012 SHALL have port dm_resumeack_o  output  1  one-cycle pulse when a resume is accepted.
REQ-013 SHALL have port dm_dpc_o  output  32  PC captured at halt; this is the resume address.
REQ-014 SHALL have port dm_drain_err_o  output  1  sticky: the last drain timed out.

Function
REQ-015 SHALL implement the FSM states RUN, DRAIN, FLUSH, HALTED, RESUME and STEP in a registered state variable.
REQ-016 SHALL decode ht_halt_active_o, ht_reset_stages_o, dm_halted_o and dm_resumeack_o purely from the state register (Moore); each responds one cycle after the triggering input is sampled.
REQ-017 SHALL drive ht_halt_active_o=1 in DRAIN, FLUSH and HALTED, and 0 in RUN, RESUME and STEP.
REQ-018 SHALL drive ht_reset_stages_o=1 only in FLUSH, which lasts exactly one cycle.
REQ-019 SHALL drive dm_halted_o=1 only in HALTED and dm_resumeack_o=1 only in RESUME.
REQ-020 SHALL transition RUN -> DRAIN when dm_haltreq_i=1; dm_resumereq_i and dm_step_i are ignored in RUN.
REQ-021 SHALL clear the 8-bit drain counter on DRAIN entry and increment it by 1 every DRAIN cycle, saturating at 255.
REQ-022 SHALL transition DRAIN -> FLUSH when ht_inst_comp_i=1, and clear dm_drain_err_o on that transition.
REQ-023 SHALL transition DRAIN -> FLUSH when the counter equals DRAIN_TIMEOUT-1 and ht_inst_comp_i=0, and set dm_drain_err_o on that transition.
REQ-024 SHALL resolve a simultaneous timeout and ht_inst_comp_i=1 as a successful drain (dm_drain_err_o cleared).
REQ-025 SHALL load dm_dpc_o with ht_pc_i on every DRAIN -> FLUSH transition and hold it otherwise; ht_pc_i is frozen by the core while ht_halt_active_o=1.
REQ-026 SHALL transition FLUSH -> HALTED unconditionally after one cycle.
REQ-027 SHALL, in HALTED, give dm_resumereq_i priority over dm_step_i and ignore dm_haltreq_i.
REQ-028 SHALL transition HALTED -> RESUME on dm_resumereq_i=1, then RESUME -> RUN after one cycle.
REQ-029 SHALL transition HALTED -> STEP on dm_step_i=1 with dm_resumereq_i=0, then STEP -> DRAIN after one cycle, so exactly one instruction is fetched.
REQ-030 SHALL require dm_resumereq_i and dm_step_i to be low before a new request is accepted in HALTED (edge qualification via one registered copy of each), so that a held level produces only one resume or step.
REQ-031 SHALL let a dm_haltreq_i still high when RUN is re-entered start a new halt on the next cycle.

Reset
REQ-032 SHALL, while reset=0, force state=RUN, counter=0, dm_dpc_o=0, dm_drain_err_o=0 and all 1-bit outputs to 0, asynchronously and independent of clk.
REQ-033 SHALL abort any state on reset assertion mid-operation, including a FLUSH in progress, with no further ht_reset_stages_o pulse after reset deasserts.

Verification
REQ-034 SHALL be covered by: haltreq at cycle 0 with inst_comp high at cycle 3 and ht_pc_i=0x40 -> halt_active high from cycle 1, FLUSH at 4, dm_halted_o high at 5, dm_dpc_o=0x40, drain_err=0.
REQ-035 SHALL be covered by: DRAIN_TIMEOUT=4 and inst_comp held 0 -> FLUSH after 4 DRAIN cycles, drain_err=1, dm_halted_o=1.
REQ-036 SHALL be covered by: from HALTED, resumereq held high 10 cycles -> single resumeack pulse, halt_active=0 in RESUME, state RUN, no second resume.
REQ-037 SHALL be covered by: from HALTED, step and resumereq high in the same cycle -> RESUME taken, no STEP.
REQ-038 SHALL be covered by: from HALTED, step pulse -> halt_active low for exactly one cycle, then DRAIN, FLUSH, HALTED with dm_dpc_o=old dpc+4 for a non-branch instruction.
REQ-039 SHALL be covered by: reset=0 asserted during FLUSH -> all outputs 0 immediately, state RUN after release, ht_reset_stages_o not re-asserted.
